// File: rtl/rtc_mode_arbiter_pkg.sv
// Shared types and constants for the RTC bus-ownership arbiter.
package rtc_mode_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_READ = 2'd1,
        ST_MODE = 2'd2
    } state_e;

    localparam logic [6:0] DEF_BOUNDARY = 7'h4A;

    localparam int CH_REINIT = 0;
    localparam int CH_TIME   = 1;
    localparam int CH_CRONO  = 2;
    localparam int CH_CRACT  = 3;

    localparam int ALARM_W = 24;

endpackage

// File: rtl/rtc_mode_arbiter_if.sv
// RTC-side bus between the arbiter and the protocol/function-generator pair.
interface rtc_mode_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 7
);
    logic [CNT_W-1:0]  bus_cnt;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              data_oe;
    logic              indicador;

    modport master (
        input  bus_cnt,
        output address,
        output data,
        output data_oe,
        output indicador
    );

    modport slave (
        output bus_cnt,
        input  address,
        input  data,
        input  data_oe,
        input  indicador
    );
endinterface

// File: rtl/rtc_mode_arbiter_alarm_cmp.sv
// Alarm comparator with a sticky ring flag; arms only while the bus is in READ.
module rtc_alarm_cmp
    import rtc_mode_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_read,
    input  logic               ring_en,
    input  logic               ring_ack,
    input  logic [ALARM_W-1:0] time_now,
    input  logic [ALARM_W-1:0] alarm_tgt,
    output logic               ring
);
    logic match_s;
    logic clear_s;
    logic ring_r;

    // An all-zero target means "no alarm programmed".
    always_comb begin
        match_s = in_read && ring_en && (time_now == alarm_tgt) && (alarm_tgt != {ALARM_W{1'b0}});
        clear_s = ring_ack || !ring_en;
    end

    // Sticky ring flag; clearing wins over a same-cycle match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ring_r <= 1'b0;
        end else if (clear_s) begin
            ring_r <= 1'b0;
        end else if (match_s) begin
            ring_r <= 1'b1;
        end else begin
            ring_r <= ring_r;
        end
    end

    assign ring = ring_r;
endmodule

// File: rtl/rtc_mode_arbiter.sv
// N-channel RTC bus-ownership arbiter: INIT / READ / MODE k, switching only at
// function-generator transaction boundaries, plus the sticky alarm comparator.
module rtc_mode_arbiter
    import rtc_mode_arbiter_pkg::*;
#(
    parameter int               N_REQ       = 4,
    parameter int               ADDR_W      = 8,
    parameter int               DATA_W      = 8,
    parameter int               CNT_W       = 7,
    parameter logic [CNT_W-1:0] BOUNDARY    = CNT_W'(DEF_BOUNDARY),
    parameter int               INIT_CYCLES = 1034
) (
    input  logic                      clk,
    input  logic                      reset,
    rtc_mode_arbiter_if.master        bus,
    input  logic [N_REQ-1:0]          req,
    input  logic [ADDR_W-1:0]         init_addr,
    input  logic [DATA_W-1:0]         init_data,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic [N_REQ*ADDR_W-1:0]   ch_addr,
    input  logic [N_REQ*DATA_W-1:0]   ch_data,
    output logic                      init_active,
    output logic [N_REQ-1:0]          mode,
    output logic                      conflict,
    input  logic [ALARM_W-1:0]        time_now,
    input  logic [ALARM_W-1:0]        alarm_tgt,
    input  logic                      ring_en,
    input  logic                      ring_ack,
    output logic                      ring
);
    localparam int               CW       = $clog2(INIT_CYCLES + 1);
    localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0]    INIT_MAX = CW'(INIT_CYCLES);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_e           state_r;
    logic [CW-1:0]    init_cnt_r;
    logic [IDX_W-1:0] mode_idx_r;
    logic             conflict_r;

    logic             boundary_s;
    logic             any_hi_s;
    logic [IDX_W-1:0] sel_s;

    // Boundary detect and lowest-index encoder over the write-type channels.
    always_comb begin
        boundary_s = (bus.bus_cnt == BOUNDARY);
        any_hi_s   = |req[N_REQ-1:1];
        sel_s      = IDX_W'(1);
        for (int i = N_REQ - 1; i >= 1; i--) begin
            sel_s = req[i] ? IDX_W'(i) : sel_s;
        end
    end

    // Mode FSM: every decision is taken on a boundary cycle and takes effect next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= '0;
            mode_idx_r <= '0;
            conflict_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r != INIT_MAX) begin
                        init_cnt_r <= init_cnt_r + CW'(1);
                    end else begin
                        init_cnt_r <= init_cnt_r;
                    end
                    if (boundary_s && (init_cnt_r == INIT_MAX)) begin
                        state_r <= ST_READ;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_READ: begin
                    if (boundary_s) begin
                        if ($countones(req) > 1) begin
                            conflict_r <= 1'b1;
                        end else begin
                            conflict_r <= conflict_r;
                        end
                        if (req[CH_REINIT]) begin
                            state_r    <= ST_INIT;
                            init_cnt_r <= '0;
                        end else if (any_hi_s) begin
                            state_r    <= ST_MODE;
                            mode_idx_r <= sel_s;
                        end else begin
                            state_r <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_READ;
                    end
                end
                ST_MODE: begin
                    // Only the owning channel's request matters; no MODE-to-MODE hop.
                    if (boundary_s && !req[mode_idx_r]) begin
                        state_r <= ST_READ;
                    end else begin
                        state_r <= ST_MODE;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= '0;
                end
            endcase
        end
    end

    // Bus mux decoded from registered state only.
    always_comb begin
        bus.address   = init_addr;
        bus.data      = init_data;
        bus.data_oe   = 1'b1;
        bus.indicador = 1'b0;
        init_active   = 1'b0;
        mode          = '0;
        case (state_r)
            ST_INIT: begin
                init_active = 1'b1;
            end
            ST_READ: begin
                bus.address   = rd_addr;
                bus.data      = '0;
                bus.data_oe   = 1'b0;
                bus.indicador = 1'b1;
            end
            ST_MODE: begin
                bus.address = ch_addr[int'(mode_idx_r)*ADDR_W +: ADDR_W];
                bus.data    = ch_data[int'(mode_idx_r)*DATA_W +: DATA_W];
                mode        = ONE_HOT0 << mode_idx_r;
            end
            default: begin
                init_active = 1'b1;
            end
        endcase
    end

    assign conflict = conflict_r;

    rtc_alarm_cmp u_alarm (
        .clk       (clk),
        .reset     (reset),
        .in_read   (state_r == ST_READ),
        .ring_en   (ring_en),
        .ring_ack  (ring_ack),
        .time_now  (time_now),
        .alarm_tgt (alarm_tgt),
        .ring      (ring)
    );
endmodule

// File: tb/tb_rtc_mode_arbiter.sv
// Directed bench for rtc_mode_arbiter: startup, boundary-gated mode table,
// re-init, alarm and asynchronous reset.
module tb_rtc_mode_arbiter;
    localparam int         N_REQ = 4;
    localparam logic [6:0] BND   = 7'h4A;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  init_addr, init_data, rd_addr;
    logic [31:0] ch_addr, ch_data;
    logic        init_active, conflict, ring;
    logic [3:0]  mode;
    logic [23:0] time_now, alarm_tgt;
    logic        ring_en, ring_ack;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    rtc_mode_arbiter_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(7)) bus_if ();

    rtc_mode_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(8), .DATA_W(8), .CNT_W(7),
        .BOUNDARY(BND), .INIT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_if), .req(req),
        .init_addr(init_addr), .init_data(init_data), .rd_addr(rd_addr),
        .ch_addr(ch_addr), .ch_data(ch_data), .init_active(init_active),
        .mode(mode), .conflict(conflict), .time_now(time_now),
        .alarm_tgt(alarm_tgt), .ring_en(ring_en), .ring_ack(ring_ack), .ring(ring)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] mode;
        logic       init_active;
        logic       indicador;
        logic       data_oe;
        logic [7:0] address;
        logic [7:0] data;
        logic       conflict;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Bus counter wraps every 75 cycles; phase 74 equals BND (0x4A).
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus_if.bus_cnt = 7'(cyc % 75);
    endtask

    task automatic boundary_step();
        int guard = 0;
        do begin
            step();
            guard++;
        end while (bus_if.bus_cnt != BND && guard < 200);
        step();
    endtask

    task automatic chk_read(input string name);
        chk({name, "_ind"}, 32'(bus_if.indicador), 32'd1);
        chk({name, "_oe"}, 32'(bus_if.data_oe), 32'd0);
        chk({name, "_addr"}, 32'(bus_if.address), 32'h3C);
        chk({name, "_mode"}, 32'(mode), 32'd0);
    endtask

    initial begin
        logic all_init;
        tbl[0] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 8'hA2, 8'h52, 1'b0};
        tbl[1] = '{4'b0110, 4'b0100, 1'b0, 1'b0, 1'b1, 8'hA2, 8'h52, 1'b0};
        tbl[2] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0};
        tbl[3] = '{4'b0110, 4'b0010, 1'b0, 1'b0, 1'b1, 8'hA1, 8'h51, 1'b1};
        tbl[4] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1};
        tbl[5] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 8'hA2, 8'h52, 1'b1};
        tbl[6] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1};
        tbl[7] = '{4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 8'hA3, 8'h53, 1'b1};
        tbl[8] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1};

        reset = 1'b1; req = 4'b0000;
        init_addr = 8'hE1; init_data = 8'h9F; rd_addr = 8'h3C;
        ch_addr = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        ch_data = {8'h53, 8'h52, 8'h51, 8'h50};
        time_now = 24'h123456; alarm_tgt = 24'h000000;
        ring_en = 1'b0; ring_ack = 1'b0;
        bus_if.bus_cnt = 7'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_active", 32'(init_active), 32'd1);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_ind", 32'(bus_if.indicador), 32'd0);
        chk("rst_oe", 32'(bus_if.data_oe), 32'd1);
        chk("rst_conflict", 32'(conflict), 32'd0);
        chk("rst_ring", 32'(ring), 32'd0);
        reset = 1'b0;
        cyc = 0;

        // Startup: first boundary is phase 74, well after the 16 init cycles.
        repeat (74) step();
        chk("startup_pre_init", 32'(init_active), 32'd1);
        chk("startup_pre_addr", 32'(bus_if.address), 32'hE1);
        step();
        chk("startup_post_init", 32'(init_active), 32'd0);
        chk_read("startup_read");

        // A request that toggles between boundaries is forgotten.
        req = 4'b0010;
        repeat (10) step();
        req = 4'b0000;
        boundary_step();
        chk_read("toggle");

        // Mid-frame request has no effect before the boundary.
        req = 4'b0100;
        repeat (5) step();
        chk("midframe_mode", 32'(mode), 32'd0);
        chk("midframe_ind", 32'(bus_if.indicador), 32'd1);

        for (int i = 0; i < 9; i++) begin
            req = tbl[i].req;
            boundary_step();
            chk($sformatf("tbl%0d_mode", i), 32'(mode), 32'(tbl[i].mode));
            chk($sformatf("tbl%0d_init", i), 32'(init_active), 32'(tbl[i].init_active));
            chk($sformatf("tbl%0d_ind", i), 32'(bus_if.indicador), 32'(tbl[i].indicador));
            chk($sformatf("tbl%0d_oe", i), 32'(bus_if.data_oe), 32'(tbl[i].data_oe));
            chk($sformatf("tbl%0d_addr", i), 32'(bus_if.address), 32'(tbl[i].address));
            chk($sformatf("tbl%0d_data", i), 32'(bus_if.data), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_conf", i), 32'(conflict), 32'(tbl[i].conflict));
        end

        // Re-init request at a boundary in READ.
        req = 4'b0001;
        boundary_step();
        req = 4'b0000;
        chk("reinit_active", 32'(init_active), 32'd1);
        chk("reinit_addr", 32'(bus_if.address), 32'hE1);
        chk("reinit_data", 32'(bus_if.data), 32'h9F);
        chk("reinit_oe", 32'(bus_if.data_oe), 32'd1);
        all_init = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            all_init = all_init & init_active;
        end
        chk("reinit_hold16", 32'(all_init), 32'd1);
        boundary_step();
        chk_read("reinit_exit");

        // Alarm: set, hold, ack, clear priority, ring_en clear, zero target.
        alarm_tgt = 24'h071500; time_now = 24'h071500; ring_en = 1'b1;
        chk("alarm_before", 32'(ring), 32'd0);
        step();
        chk("alarm_set", 32'(ring), 32'd1);
        time_now = 24'h071501;
        step();
        chk("alarm_hold", 32'(ring), 32'd1);
        ring_ack = 1'b1;
        step();
        chk("alarm_ack", 32'(ring), 32'd0);
        time_now = 24'h071500;
        step();
        chk("alarm_clr_prio", 32'(ring), 32'd0);
        ring_ack = 1'b0;
        step();
        chk("alarm_reset", 32'(ring), 32'd1);
        ring_en = 1'b0;
        step();
        chk("alarm_en_clr", 32'(ring), 32'd0);
        ring_en = 1'b1; alarm_tgt = 24'h000000; time_now = 24'h000000;
        repeat (3) step();
        chk("alarm_zero_tgt", 32'(ring), 32'd0);

        // Arm ring, enter MODE 3, then hit asynchronous reset mid-cycle.
        alarm_tgt = 24'h235959; time_now = 24'h235959;
        step();
        time_now = 24'h000001;
        req = 4'b1000;
        boundary_step();
        chk("m3_mode", 32'(mode), 32'h8);
        chk("m3_addr", 32'(bus_if.address), 32'hA3);
        chk("m3_ring", 32'(ring), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_init_active", 32'(init_active), 32'd1);
        chk("arst_mode", 32'(mode), 32'd0);
        chk("arst_ind", 32'(bus_if.indicador), 32'd0);
        chk("arst_oe", 32'(bus_if.data_oe), 32'd1);
        chk("arst_addr", 32'(bus_if.address), 32'hE1);
        chk("arst_conflict", 32'(conflict), 32'd0);
        chk("arst_ring", 32'(ring), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
